// File: rtl/generador_bounty.sv
// Nonce-search controller: appends nonces to the latched block, asks the hash core for a digest and
// publishes the first nonce whose hash MSBs fall below the target. Optional macro GENERADOR_LIMITE_EN.
module generador_bounty #(
   parameter int unsigned        BLK_W     = 96,
   parameter int unsigned        NONCE_W   = 24,
   parameter int unsigned        TARGET_W  = 8,
   parameter logic [NONCE_W-1:0] MAX_NONCE = '1
) (
   input  logic                     clk,
   input  logic                     reset_L,
   input  logic                     start,
   input  logic [1:0]               rd_ptr,
   input  logic [BLK_W-1:0]         bloque_in,
   input  logic [TARGET_W-1:0]      target,
   output logic                     hash_req,
   output logic [BLK_W+NONCE_W-1:0] hash_data,
   input  logic                     hash_ack,
   input  logic [23:0]              hash_in,
   output logic [NONCE_W-1:0]       bounty,
   output logic                     bounty_valid,
   output logic                     busy,
   output logic                     agotado
);

   localparam int unsigned HASH_W = 24;

`ifdef GENERADOR_LIMITE_EN
   localparam bit LimitEn = 1'b1;
`else
   localparam bit LimitEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StCheck,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [BLK_W-1:0]      bloque_lat_q, bloque_lat_d;
   logic [1:0]            ptr_lat_q, ptr_lat_d;
   logic [TARGET_W-1:0]   target_lat_q, target_lat_d;
   logic [TARGET_W-1:0]   hash_lat_q, hash_lat_d;
   logic [NONCE_W-1:0]    nonce_q, nonce_d;
   logic [NONCE_W-1:0]    bounty_q, bounty_d;
   logic                  bounty_valid_q, bounty_valid_d;
   logic                  agotado_q, agotado_d;

   logic                  entry_latch;
   logic                  hit;
   logic                  limit_reached;

   // Only the compared MSB slice of the digest matters.
   logic unused_hash_lsbs;
   assign unused_hash_lsbs = ^hash_in[HASH_W-TARGET_W-1:0];

   assign hit           = (hash_lat_q < target_lat_q);
   assign limit_reached = LimitEn && (nonce_q == MAX_NONCE);

   always_comb begin
      state_d        = state_q;
      bloque_lat_d   = bloque_lat_q;
      ptr_lat_d      = ptr_lat_q;
      target_lat_d   = target_lat_q;
      hash_lat_d     = hash_lat_q;
      nonce_d        = nonce_q;
      bounty_d       = bounty_q;
      bounty_valid_d = 1'b0;
      agotado_d      = agotado_q;
      entry_latch    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) entry_latch = 1'b1;
         end
         StReq: begin
            if (hash_ack) begin
               hash_lat_d = hash_in[HASH_W-1 -: TARGET_W];
               state_d    = StCheck;
            end
         end
         StCheck: begin
            if (hit) begin
               bounty_d       = nonce_q;
               bounty_valid_d = 1'b1;
               state_d        = StDone;
            end else if (limit_reached) begin
               // Exhausted range still publishes so the output stage advances.
               agotado_d      = 1'b1;
               bounty_d       = MAX_NONCE;
               bounty_valid_d = 1'b1;
               state_d        = StDone;
            end else begin
               nonce_d = nonce_q + NONCE_W'(1);
               state_d = StReq;
            end
         end
         StDone: begin
            // The output stage advancing rd_ptr is what chains the next search.
            if (rd_ptr != ptr_lat_q) entry_latch = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      if (entry_latch) begin
         bloque_lat_d = bloque_in;
         ptr_lat_d    = rd_ptr;
         target_lat_d = target;
         nonce_d      = '0;
         agotado_d    = 1'b0;
         state_d      = StReq;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q        <= StIdle;
         bloque_lat_q   <= '0;
         ptr_lat_q      <= '0;
         target_lat_q   <= '0;
         hash_lat_q     <= '0;
         nonce_q        <= '0;
         bounty_q       <= '0;
         bounty_valid_q <= 1'b0;
         agotado_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         bloque_lat_q   <= bloque_lat_d;
         ptr_lat_q      <= ptr_lat_d;
         target_lat_q   <= target_lat_d;
         hash_lat_q     <= hash_lat_d;
         nonce_q        <= nonce_d;
         bounty_q       <= bounty_d;
         bounty_valid_q <= bounty_valid_d;
         agotado_q      <= agotado_d;
      end
   end

   assign hash_req     = (state_q == StReq);
   assign hash_data    = {bloque_lat_q, nonce_q};
   assign busy         = (state_q == StReq) || (state_q == StCheck);
   assign bounty       = bounty_q;
   assign bounty_valid = bounty_valid_q;
   assign agotado      = agotado_q;

`ifndef SYNTHESIS
   a_req_stable: assert property (@(posedge clk) disable iff (!reset_L)
      (state_q == StReq && !hash_ack) |=> $stable(hash_data) && hash_req);

   a_valid_in_done: assert property (@(posedge clk) disable iff (!reset_L)
      bounty_valid |-> (state_q == StDone));

   a_valid_pulse: assert property (@(posedge clk) disable iff (!reset_L)
      bounty_valid |=> !bounty_valid);
`endif

endmodule

// File: tb/tb_generador_bounty.sv
// Directed bench for generador_bounty: hash core model with programmable ack delay and winning nonce.
module tb_generador_bounty;

   localparam logic [95:0] BlkA = 96'h0123_4567_89AB_CDEF_0011_2233;
   localparam logic [95:0] BlkB = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
   localparam logic [95:0] BlkC = 96'h5A5A_A5A5_0F0F_F0F0_8765_4321;

`ifdef GENERADOR_LIMITE_EN
   localparam logic [23:0] TbMax = 24'd3;
`else
   localparam logic [23:0] TbMax = 24'hFFFFFF;
`endif

   logic          clk = 1'b0;
   logic          reset_L;
   logic          start;
   logic [1:0]    rd_ptr;
   logic [95:0]   bloque_in;
   logic [7:0]    target;
   logic          hash_req;
   logic [119:0]  hash_data;
   logic          hash_ack;
   logic [23:0]   hash_in;
   logic [23:0]   bounty;
   logic          bounty_valid;
   logic          busy;
   logic          agotado;

   int            checks = 0;
   int            errors = 0;
   int            ack_delay = 0;
   int            wait_cnt = 0;
   logic [23:0]   win_nonce = '0;
   logic [23:0]   win_hash = '0;
   logic [23:0]   lose_hash = 24'hFF0000;

   generador_bounty #(
      .BLK_W     (96),
      .NONCE_W   (24),
      .TARGET_W  (8),
      .MAX_NONCE (TbMax)
   ) dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .start        (start),
      .rd_ptr       (rd_ptr),
      .bloque_in    (bloque_in),
      .target       (target),
      .hash_req     (hash_req),
      .hash_data    (hash_data),
      .hash_ack     (hash_ack),
      .hash_in      (hash_in),
      .bounty       (bounty),
      .bounty_valid (bounty_valid),
      .busy         (busy),
      .agotado      (agotado)
   );

   always #5 clk = ~clk;

   // Hash core: acks after ack_delay waiting cycles, answers from the nonce field.
   always @(posedge clk) begin
      if (hash_req === 1'b1 && hash_ack !== 1'b1) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end
   assign hash_ack = (hash_req === 1'b1) && (wait_cnt >= ack_delay);
   assign hash_in  = (hash_data[23:0] == win_nonce) ? win_hash : lose_hash;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   task automatic wait_valid(input int max_cycles, input string tag);
      int n = 0;
      while (bounty_valid !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {127'd0, bounty_valid}, 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_L   = 1'b0;
      start     = 1'b0;
      rd_ptr    = 2'd0;
      bloque_in = '0;
      target    = '0;
      #1;
      chk("rst_hash_req", 128'(hash_req), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_bounty", 128'(bounty), 128'd0);
      chk("rst_valid", 128'(bounty_valid), 128'd0);
      chk("rst_agotado", 128'(agotado), 128'd0);
      chk("rst_hash_data", 128'(hash_data), 128'd0);
      repeat (2) @(negedge clk);
      reset_L = 1'b1;
      @(negedge clk);

      // Immediate hit on nonce 0: bounty visible 3 edges after the start edge.
      bloque_in = BlkA;
      rd_ptr    = 2'd0;
      target    = 8'h10;
      win_nonce = 24'd0;
      win_hash  = 24'h0F0000;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("imm_req", 128'(hash_req), 128'd1);
      chk("imm_data", 128'(hash_data), 128'({BlkA, 24'd0}));
      @(negedge clk);
      chk("imm_check_req", 128'(hash_req), 128'd0);
      chk("imm_check_busy", 128'(busy), 128'd1);
      chk("imm_no_early_valid", 128'(bounty_valid), 128'd0);
      @(negedge clk);
      chk("imm_valid", 128'(bounty_valid), 128'd1);
      chk("imm_bounty", 128'(bounty), 128'd0);
      chk("imm_busy_done", 128'(busy), 128'd0);
      @(negedge clk);
      chk("imm_valid_pulse", 128'(bounty_valid), 128'd0);

`ifndef GENERADOR_LIMITE_EN
      // Search: nonces 0..4 miss, nonce 5 hits; one REQ and one CHECK cycle each.
      do_reset();
      bloque_in = BlkB;
      target    = 8'h06;
      win_nonce = 24'd5;
      win_hash  = 24'h050000;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("srch_nonce%0d", k), 128'(hash_data[23:0]), 128'(k));
         chk($sformatf("srch_req%0d", k), 128'(hash_req), 128'd1);
         @(negedge clk);
         chk($sformatf("srch_chk%0d", k), 128'(hash_req), 128'd0);
         @(negedge clk);
      end
      chk("srch_bounty", 128'(bounty), 128'd5);
      chk("srch_valid", 128'(bounty_valid), 128'd1);
      chk("srch_blk", 128'(hash_data[119:24]), 128'(BlkB));

      // Target 0 never hits; async reset mid-REQ must clear everything at once.
      target = 8'h00;
      rd_ptr = 2'd2;
      @(negedge clk);
      chk("t0_busy", 128'(busy), 128'd1);
      chk("t0_nonce0", 128'(hash_data[23:0]), 128'd0);
      repeat (6) @(negedge clk);
      chk("t0_still_busy", 128'(busy), 128'd1);
      chk("t0_bounty_held", 128'(bounty), 128'd5);
      chk("t0_in_req", 128'(hash_req), 128'd1);
      #2;
      reset_L = 1'b0;
      #1;
      chk("async_req", 128'(hash_req), 128'd0);
      chk("async_busy", 128'(busy), 128'd0);
      chk("async_bounty", 128'(bounty), 128'd0);
      @(negedge clk);
      reset_L = 1'b1;
      rd_ptr  = 2'd0;
`endif

      // Prior search leaves DONE with ptr 0 and bounty 3.
      do_reset();
      bloque_in = BlkA;
      rd_ptr    = 2'd0;
      target    = 8'h06;
      win_nonce = 24'd3;
      win_hash  = 24'h050000;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(20, "pre_valid_timeout");
      chk("pre_bounty", 128'(bounty), 128'd3);

      // Chaining on rd_ptr change, with the ack held off for 4 cycles.
      ack_delay = 4;
      win_nonce = 24'd1;
      win_hash  = 24'h020000;
      bloque_in = BlkC;
      rd_ptr    = 2'd1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stall_req%0d", i), 128'(hash_req), 128'd1);
         chk($sformatf("stall_data%0d", i), 128'(hash_data), 128'({BlkC, 24'd0}));
         @(negedge clk);
      end
      chk("stall_ack_data", 128'(hash_data), 128'({BlkC, 24'd0}));
      @(negedge clk);
      chk("stall_drop_req", 128'(hash_req), 128'd0);
      wait_valid(40, "chain_valid_timeout");
      chk("chain_bounty", 128'(bounty), 128'd1);
      chk("chain_agotado", 128'(agotado), 128'd0);
      ack_delay = 0;

`ifdef GENERADOR_LIMITE_EN
      // Limit: target 0 with MAX_NONCE 3 exhausts after 4 misses.
      do_reset();
      target    = 8'h00;
      win_nonce = 24'hFFFFFF;
      rd_ptr    = 2'd0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("lim_not_yet", 128'(agotado), 128'd0);
      chk("lim_no_valid", 128'(bounty_valid), 128'd0);
      @(negedge clk);
      chk("lim_agotado", 128'(agotado), 128'd1);
      chk("lim_bounty", 128'(bounty), 128'd3);
      chk("lim_valid", 128'(bounty_valid), 128'd1);
      @(negedge clk);
      chk("lim_valid_pulse", 128'(bounty_valid), 128'd0);
      chk("lim_busy", 128'(busy), 128'd0);
      rd_ptr = 2'd3;
      @(negedge clk);
      chk("lim_clear", 128'(agotado), 128'd0);
      chk("lim_restart", 128'(busy), 128'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/generador_bounty.md
# generador_bounty

Nonce-search controller placed directly upstream of the output stage (`salidas`). For the input entry selected by `rd_ptr`, it appends successive 24-bit nonces to the 96-bit block, requests a hash from the hash core, and compares each result against a target. The first qualifying nonce is published on `bounty`. The output stage detects that change and advances `rd_ptr`, which starts the search on the next entry.

## Interface
- `BLK_W`, 96: block width without nonce.
- `NONCE_W`, 24: nonce and bounty width.
- `TARGET_W`, 8: compared MSB slice of hash.
- `MAX_NONCE`, 24'hFFFFFF: last nonce tried (used only with `GENERADOR_LIMITE_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a search on the current entry.
- `rd_ptr` in 2: entry index driven by the output stage.
- `bloque_in` in BLK_W: block data for entry `rd_ptr`.
- `target` in TARGET_W: hit when `hash_in[23:16] < target`.
- `hash_req` out 1: request to hash core.
- `hash_data` out BLK_W+NONCE_W: `{bloque_lat, nonce}`.
- `hash_ack` in 1: hash core accepts the request and returns the result in the same cycle.
- `hash_in` in 24: hash result, valid when `hash_ack` is 1.
- `bounty` out NONCE_W: last winning nonce.
- `bounty_valid` out 1: one-cycle pulse when `bounty` updates.
- `busy` out 1: high whenever the state is not IDLE or DONE.
- `agotado` out 1: nonce range exhausted (limit build only).

## Operation
- States: IDLE, REQ, CHECK, DONE.
- IDLE:
  - `start`=1 → latch `bloque_in` into `bloque_lat`, `rd_ptr` into `ptr_lat`, and `target`.
  - Set nonce=0, go to REQ.
- REQ:
  - `hash_req`=1, `hash_data` held stable.
  - When `hash_ack`=1, latch `hash_in[23:16]` and go to CHECK.
  - `hash_req` drops in the cycle after the ack.
- CHECK (single cycle):
  - Hit (`hash_lat < target_lat`, unsigned) → `bounty`<=nonce, `bounty_valid` pulse, go to DONE.
  - Miss → nonce<=nonce+1 (NONCE_W bits, wraps 24'hFFFFFF→0), go back to REQ.
- DONE: holds `bounty`. A `rd_ptr` value different from `ptr_lat` acts as an automatic start on the new entry: latch the inputs, nonce=0, go to REQ.
- `start` while `busy` is ignored.
- `rd_ptr` changes in REQ/CHECK are ignored; the pointer is re-evaluated on entering DONE.
- `target`=0 can never hit. In the no-limit build the search runs forever; only `reset_L` escapes it.
- A repeat winning nonce equal to the previous `bounty` still pulses `bounty_valid`, but `bounty` does not change. The output stage then stalls; this is a documented system limitation.

## Timing
- Reset values:
  - state=IDLE; `hash_req`, `bounty_valid`, `busy`, `agotado` = 0.
  - `bounty`=0, nonce=0, all latches=0.
- `reset_L` deasserted mid-search: state returns to IDLE immediately, asynchronously. No request survives.
- Best case, `start` to `bounty` update: `start` cycle + REQ (ack in first REQ cycle) + CHECK = `bounty` visible 3 edges after the `start` edge.
- Per-nonce throughput: 2 cycles plus ack wait.
- `hash_data` changes only on CHECK→REQ transitions and on entry latch.

## Configuration
- `GENERADOR_LIMITE_EN` defined:
  - In CHECK, a miss with nonce==MAX_NONCE → `agotado`=1, `bounty`<=MAX_NONCE, `bounty_valid` pulse, go to DONE, so the output stage still advances.
  - `agotado` clears on the next entry latch.
- Not defined: nonce wraps and the search continues indefinitely; `agotado` is tied to 0.

## Test plan
- Reset: drive `reset_L`=0 asynchronously mid-REQ → `hash_req`=0, `bounty`=0, `busy`=0 with no clock edge needed.
- Immediate hit: `target`=8'h10, hash core returns 24'h0F0000 on nonce 0, ack every cycle → `bounty`=0, one `bounty_valid` pulse 3 edges after `start`.
- Search sequence: core returns 24'hFF0000 for nonces 0–4 and 24'h050000 for nonce 5, with `target`=8'h06 → `bounty`=5 after 12 cycles; `hash_data[23:0]` steps 0..5.
- Ack stall: ack delayed 4 cycles → `hash_req` and `hash_data` stable throughout; nonce does not advance.
- Chaining: after a hit, set `rd_ptr` 0→1 with a new `bloque_in` → new search starts with nonce=0 and `hash_data[119:24]` equal to the new block.
- Limit (`GENERADOR_LIMITE_EN`, MAX_NONCE=3, `target`=0) → `agotado`=1, `bounty`=3 after 4 misses, `bounty_valid` pulsed once.
